// File: rtl/axi4_frame_writer.sv
// Packs RGB565 pixels four per 64-bit word into a 64-entry staging buffer and
// writes each full buffer as one 64-beat INCR AXI4 burst into a double-buffered frame store.
module axi4_frame_writer #(
  parameter int          AXI_ADDR_WIDTH   = 32,
  parameter int          AXI_DATA_WIDTH   = 64,
  parameter int          BURSTS_PER_FRAME = 300,
  parameter logic [31:0] BUF0_BASE        = 32'h0100_0000,
  parameter logic [31:0] BUF1_BASE        = 32'h0110_0000
) (
  input  logic                      clk_100Mhz,
  input  logic                      rst_n,
  input  logic [15:0]               pix_data,
  input  logic                      pix_valid,
  output logic                      pix_ready,
  input  logic                      frame_start,
  output logic [AXI_ADDR_WIDTH-1:0] AWADDR,
  output logic                      AWVALID,
  input  logic                      AWREADY,
  output logic [7:0]                AWLEN,
  output logic [2:0]                AWSIZE,
  output logic [1:0]                AWBURST,
  output logic [3:0]                AWCACHE,
  output logic [AXI_DATA_WIDTH-1:0] WDATA,
  output logic [7:0]                WSTRB,
  output logic                      WVALID,
  input  logic                      WREADY,
  output logic                      WLAST,
  input  logic [1:0]                BRESP,
  input  logic                      BVALID,
  output logic                      BREADY,
  output logic                      buf_select,
  output logic                      frame_done,
  output logic                      resp_err,
  output logic [2:0]                state
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    FILL       = 3'd1,
    ADDR_SEND  = 3'd2,
    DATA_WRITE = 3'd3,
    RESP_WAIT  = 3'd4
  } state_t;

  localparam logic [8:0] LAST_BURST = 9'(BURSTS_PER_FRAME - 1);

  state_t      state_reg, state_next;
  logic [63:0] staging [64];
  logic [5:0]  beat_cnt_reg;
  logic [5:0]  rd_idx_reg;
  logic [1:0]  lane_reg;
  logic [47:0] pack_reg;
  logic [8:0]  burst_cnt_reg;
  logic        fs_pending_reg;
  logic [31:0] target_base;

  logic pix_fire, word_wr, aw_fire, w_fire, b_fire, last_beat, last_burst;

  assign AWLEN   = 8'd63;
  assign AWSIZE  = 3'b011;
  assign AWBURST = 2'b01;
  assign AWCACHE = 4'b1111;
  assign WSTRB   = 8'hFF;

  // Handshake-facing strobes follow the state register directly, so reset clears them at once.
  assign pix_ready = (state_reg == FILL);
  assign AWVALID   = (state_reg == ADDR_SEND);
  assign WVALID    = (state_reg == DATA_WRITE);
  assign BREADY    = (state_reg == RESP_WAIT);
  assign WLAST     = WVALID && last_beat;
  assign state     = state_reg;

  assign pix_fire   = pix_valid && pix_ready;
  assign word_wr    = pix_fire && !frame_start && (lane_reg == 2'd3);
  assign aw_fire    = AWVALID && AWREADY;
  assign w_fire     = WVALID && WREADY;
  assign b_fire     = BVALID && BREADY;
  assign last_beat  = (rd_idx_reg == 6'd63);
  assign last_burst = (burst_cnt_reg == LAST_BURST);

  // buf_select resets to 0 and the first frame lands in BUF1; each frame flips the target.
  assign target_base = buf_select ? BUF0_BASE : BUF1_BASE;

  always_ff @(posedge clk_100Mhz or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:       state_next = FILL;
      FILL:       if (word_wr && beat_cnt_reg == 6'd63) state_next = ADDR_SEND;
      ADDR_SEND:  if (aw_fire) state_next = DATA_WRITE;
      DATA_WRITE: if (w_fire && last_beat) state_next = RESP_WAIT;
      RESP_WAIT:  if (b_fire) state_next = FILL;
      default:    state_next = IDLE;
    endcase
  end

  // Staging buffer: plain array with no reset so it maps onto block RAM.
  always_ff @(posedge clk_100Mhz) begin
    if (word_wr) staging[beat_cnt_reg] <= {pack_reg, pix_data};
  end

  always_ff @(posedge clk_100Mhz or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt_reg   <= '0;
      rd_idx_reg     <= '0;
      lane_reg       <= '0;
      pack_reg       <= '0;
      burst_cnt_reg  <= '0;
      fs_pending_reg <= 1'b0;
      AWADDR         <= '0;
      WDATA          <= '0;
      buf_select     <= 1'b0;
      frame_done     <= 1'b0;
      resp_err       <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (frame_start && (state_reg == ADDR_SEND || state_reg == DATA_WRITE ||
                          state_reg == RESP_WAIT))
        fs_pending_reg <= 1'b1;
      case (state_reg)
        FILL: begin
          if (frame_start) begin
            // Partial data is dropped; a pixel arriving with the pulse starts the new frame.
            beat_cnt_reg   <= '0;
            burst_cnt_reg  <= '0;
            fs_pending_reg <= 1'b0;
            lane_reg       <= pix_fire ? 2'd1 : 2'd0;
            if (pix_fire) pack_reg[47:32] <= pix_data;
          end else if (pix_fire) begin
            lane_reg <= lane_reg + 2'd1;
            case (lane_reg)
              2'd0:    pack_reg[47:32] <= pix_data;
              2'd1:    pack_reg[31:16] <= pix_data;
              2'd2:    pack_reg[15:0]  <= pix_data;
              default: begin
                beat_cnt_reg <= beat_cnt_reg + 6'd1;
                if (beat_cnt_reg == 6'd63)
                  AWADDR <= AXI_ADDR_WIDTH'(target_base + {14'd0, burst_cnt_reg, 9'd0});
              end
            endcase
          end
        end
        ADDR_SEND: begin
          if (aw_fire) begin
            rd_idx_reg <= '0;
            WDATA      <= AXI_DATA_WIDTH'(staging[6'd0]);
          end
        end
        DATA_WRITE: begin
          // Next word is fetched only on a handshake, so WDATA holds through stalls.
          if (w_fire && !last_beat) begin
            rd_idx_reg <= rd_idx_reg + 6'd1;
            WDATA      <= AXI_DATA_WIDTH'(staging[rd_idx_reg + 6'd1]);
          end
        end
        RESP_WAIT: begin
          if (b_fire) begin
            if (BRESP != 2'b00) resp_err <= 1'b1;
            beat_cnt_reg   <= '0;
            lane_reg       <= '0;
            fs_pending_reg <= 1'b0;
            if (last_burst) begin
              buf_select <= ~buf_select;
              frame_done <= 1'b1;
            end
            if (last_burst || fs_pending_reg || frame_start) burst_cnt_reg <= '0;
            else                                             burst_cnt_reg <= burst_cnt_reg + 9'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_frame_writer.sv
// Self-checking bench for axi4_frame_writer: table of bursts plus frame_start and reset corner sequences,
// with scoreboard queues for expected AW addresses and W data words.
module tb_axi4_frame_writer;

  localparam int BPF = 4;  // short frames keep the run small; addressing is identical per burst

  logic        clk_100Mhz = 1'b0;
  logic        rst_n;
  logic [15:0] pix_data;
  logic        pix_valid, pix_ready, frame_start;
  logic [31:0] AWADDR;
  logic        AWVALID, AWREADY;
  logic [7:0]  AWLEN;
  logic [2:0]  AWSIZE;
  logic [1:0]  AWBURST;
  logic [3:0]  AWCACHE;
  logic [63:0] WDATA;
  logic [7:0]  WSTRB;
  logic        WVALID, WREADY, WLAST;
  logic [1:0]  BRESP;
  logic        BVALID, BREADY;
  logic        buf_select, frame_done, resp_err;
  logic [2:0]  state;

  axi4_frame_writer #(.BURSTS_PER_FRAME(BPF)) dut (
    .clk_100Mhz(clk_100Mhz), .rst_n(rst_n), .pix_data(pix_data), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .frame_start(frame_start), .AWADDR(AWADDR), .AWVALID(AWVALID),
    .AWREADY(AWREADY), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST), .AWCACHE(AWCACHE),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY), .WLAST(WLAST),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY), .buf_select(buf_select),
    .frame_done(frame_done), .resp_err(resp_err), .state(state)
  );

  always #5 clk_100Mhz = ~clk_100Mhz;

  typedef struct {
    int          base;
    int          aw_delay;
    bit          w_rand;
    logic [1:0]  bresp;
    logic [31:0] exp_addr;
    bit          exp_fd;
    bit          exp_bsel;
    bit          exp_err;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] aq[$];
  logic [63:0] wq[$];

  // responder controls / expectations (set by main, used by responder)
  int          aw_delay = 0;
  bit          w_rand   = 0;
  logic [1:0]  bresp_val = 2'b00;
  bit          exp_fd = 0, exp_bsel = 0, exp_err = 0;
  // responder state
  int          aw_wait = 0, w_beats = 0, b_done = 0;
  bit          aw_seen = 0, aw_stall = 0, w_stall = 0, b_prev = 0;
  logic [31:0] aw_hold;
  logic [63:0] w_hold;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // AXI slave model: decides readies at each negedge, handshake completes at the next posedge.
  initial begin
    AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 0;
    forever begin
      @(negedge clk_100Mhz);
      chk("frame_done_pulse", {63'd0, frame_done}, {63'd0, b_prev && exp_fd});
      if (b_prev) begin
        chk("buf_select_after_b", {63'd0, buf_select}, {63'd0, exp_bsel});
        chk("resp_err_after_b", {63'd0, resp_err}, {63'd0, exp_err});
        b_done++;
      end
      b_prev = 0;

      if (aw_stall) chk("awaddr_stable", {31'd0, AWVALID, AWADDR}, {31'd0, 1'b1, aw_hold});
      if (AWVALID) begin
        AWREADY = (aw_wait >= aw_delay);
        aw_wait++;
        if (AWREADY) begin
          if (aq.size() == 0) chk("aw_unexpected", 64'd1, 64'd0);
          else chk("awaddr", {32'd0, AWADDR}, {32'd0, aq.pop_front()});
          aw_wait = 0; aw_seen = 1; aw_stall = 0;
        end else begin
          aw_stall = 1; aw_hold = AWADDR;
        end
      end else begin
        AWREADY = 0; aw_stall = 0;
      end

      if (w_stall) begin
        chk("wdata_stable", WDATA, w_hold);
        chk("wvalid_stable", {63'd0, WVALID}, 64'd1);
      end
      if (WVALID) begin
        WREADY = w_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        if (WREADY) begin
          chk("w_after_aw", {63'd0, aw_seen}, 64'd1);
          if (wq.size() == 0) chk("w_unexpected", 64'd1, 64'd0);
          else chk("wdata", WDATA, wq.pop_front());
          chk("wlast", {63'd0, WLAST}, {63'd0, w_beats == 63});
          w_beats++;
          if (w_beats == 64) begin w_beats = 0; aw_seen = 0; end
          w_stall = 0;
        end else begin
          w_stall = 1; w_hold = WDATA;
        end
      end else begin
        WREADY = 0; w_stall = 0;
      end

      BVALID = BREADY;
      BRESP  = BREADY ? bresp_val : 2'b00;
      if (BREADY) b_prev = 1;
    end
  end

  task automatic drive_pixels(input int base, input int n, input bit push, input bit fs_first);
    logic [63:0] word = '0;
    for (int k = 0; k < n; k++) begin
      int  t = 0;
      bit  done = 0;
      while (!done) begin
        @(negedge clk_100Mhz);
        if (pix_ready && ((fs_first && k == 0) || $urandom_range(0, 3) != 0)) begin
          pix_valid = 1; pix_data = 16'(base + k);
          frame_start = fs_first && (k == 0);
          done = 1;
        end else begin
          pix_valid = 0; frame_start = 0;
        end
        t++;
        if (!done && t > 3000) begin
          $display("FAIL pix_ready_timeout: got 0 expected 1");
          n_fail++;
          $fatal(1, "pixel stream stalled");
        end
      end
      word = {word[47:0], 16'(base + k)};
      if (push && (k % 4 == 3)) wq.push_back(word);
    end
    @(negedge clk_100Mhz);
    pix_valid = 0; frame_start = 0;
  endtask

  task automatic wait_b();
    int start = b_done;
    int t = 0;
    while (b_done == start && t < 5000) begin @(negedge clk_100Mhz); t++; end
    chk("b_handshake_seen", {63'd0, b_done != start}, 64'd1);
  endtask

  task automatic wait_state(input logic [2:0] s);
    int t = 0;
    while (state !== s && t < 2000) begin @(negedge clk_100Mhz); t++; end
    chk("wait_state", {61'd0, state}, {61'd0, s});
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{0,    0, 0, 2'b00, 32'h0110_0000, 0, 0, 0};
    vecs[1] = '{256,  5, 1, 2'b00, 32'h0110_0200, 0, 0, 0};
    vecs[2] = '{512,  0, 1, 2'b00, 32'h0110_0400, 0, 0, 0};
    vecs[3] = '{768,  2, 0, 2'b00, 32'h0110_0600, 1, 1, 0};
    vecs[4] = '{1024, 0, 0, 2'b10, 32'h0100_0000, 0, 1, 1};
    vecs[5] = '{1280, 3, 1, 2'b00, 32'h0100_0200, 0, 1, 1};

    rst_n = 0; pix_valid = 0; pix_data = 0; frame_start = 0;
    repeat (3) @(negedge clk_100Mhz);
    chk("rst_state", {61'd0, state}, 64'd0);
    chk("rst_outputs", {53'd0, pix_ready, AWVALID, WVALID, WLAST, BREADY, buf_select,
                        frame_done, resp_err, 3'd0}, 64'd0);
    chk("rst_awaddr", {32'd0, AWADDR}, 64'd0);
    chk("rst_wdata", WDATA, 64'd0);
    chk("axi_constants", {37'd0, AWLEN, AWSIZE, AWBURST, AWCACHE, WSTRB},
        {37'd0, 8'd63, 3'b011, 2'b01, 4'b1111, 8'hFF});
    rst_n = 1;
    @(negedge clk_100Mhz);
    chk("fill_after_reset", {61'd0, state}, 64'd1);
    chk("pix_ready_fill", {63'd0, pix_ready}, 64'd1);

    for (int i = 0; i < 6; i++) begin
      aw_delay = vecs[i].aw_delay; w_rand = vecs[i].w_rand; bresp_val = vecs[i].bresp;
      exp_fd = vecs[i].exp_fd; exp_bsel = vecs[i].exp_bsel; exp_err = vecs[i].exp_err;
      aq.push_back(vecs[i].exp_addr);
      drive_pixels(vecs[i].base, 256, 1, 0);
      wait_b();
      $display("burst %0d: base %0d addr %h done, buf_select=%0b resp_err=%0b",
               i, vecs[i].base, vecs[i].exp_addr, buf_select, resp_err);
    end

    // frame_start after 100 pixels: partial data dropped, burst counter restarts
    aw_delay = 0; w_rand = 1; bresp_val = 2'b00; exp_fd = 0; exp_bsel = 1; exp_err = 1;
    drive_pixels(9000, 100, 0, 0);
    aq.push_back(32'h0100_0000);
    drive_pixels(20000, 256, 1, 1);
    wait_b();
    $display("seq fs_in_fill: addr 0100_0000 done");

    // frame_start during DATA_WRITE: burst finishes, next burst restarts at the base
    aq.push_back(32'h0100_0200);
    drive_pixels(30000, 256, 1, 0);
    wait_state(3'd3);
    frame_start = 1;
    @(negedge clk_100Mhz);
    frame_start = 0;
    wait_b();
    aq.push_back(32'h0100_0000);
    drive_pixels(31000, 256, 1, 0);
    wait_b();
    $display("seq fs_in_burst: addr 0100_0200 then 0100_0000 done");

    // reset in the middle of a burst at beat 20
    aq.push_back(32'h0100_0200);
    drive_pixels(40000, 256, 1, 0);
    begin
      int t = 0;
      while (w_beats < 20 && t < 2000) begin @(negedge clk_100Mhz); t++; end
      chk("beat20_reached", {63'd0, w_beats >= 20}, 64'd1);
    end
    rst_n = 0;
    #1;
    chk("midrst_outputs", {53'd0, pix_ready, AWVALID, WVALID, WLAST, BREADY, buf_select,
                           frame_done, resp_err, 3'd0}, 64'd0);
    chk("midrst_state", {61'd0, state}, 64'd0);
    chk("midrst_awaddr_wdata", {32'd0, AWADDR} | WDATA, 64'd0);
    aq.delete(); wq.delete();
    w_beats = 0; aw_seen = 0; aw_stall = 0; w_stall = 0; aw_wait = 0;
    repeat (2) @(negedge clk_100Mhz);
    rst_n = 1;
    exp_fd = 0; exp_bsel = 0; exp_err = 0;
    aq.push_back(32'h0110_0000);
    drive_pixels(0, 256, 1, 0);
    wait_b();
    $display("seq reset_mid_burst: restart at 0110_0000 done");

    chk("aq_drained", 64'(aq.size()), 64'd0);
    chk("wq_drained", 64'(wq.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
